// File: rtl/gfx_pkg.sv
// Shared types and default sizes for the frame blit scheduler.
// No logic beyond one combinational helper function.
// No handshake of its own.
package gfx_pkg;

  localparam int FRAME_BITS_DEF = 2;
  localparam int WORD_BITS_DEF  = 10;
  localparam int DATA_W_DEF     = 16;
  localparam logic [7:0] SEL_BASE_DEF = 8'h31;

  typedef enum logic [3:0] {
    IDLE,
    T_ACK,
    COPY,
    FLUSH,
    DRAW,
    SKIP,
    S_ACK,
    S_LATCH,
    S_END
  } blitState_t;

  // True when a key offset names a stored frame (offset < 2^frameBits).
  // The offset has already wrapped in 8 bits, so codes below the base
  // become large values and are rejected here as well.
  function automatic logic selValid(input logic [7:0] code, input int frameBits);
    logic [31:0] wide;
    wide = 32'(code);
    return (wide >> frameBits) == 32'd0;
  endfunction

endpackage

// File: rtl/blit_pipe.sv
// Copy datapath: read-address counter plus a one-stage write delay.
// Latency: each word is written one cycle after its read is issued.
// No backpressure: once started it streams every word of the frame.
//
// Ports: CLK, IN_PB_RESET (async active-low); start pulse and frame number
// from the FSM; source RAM read port (SRC_*); VRAM write port (DST_*);
// done is high in the cycle that issues the read of the last word.
module blit_pipe
  import gfx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                           CLK,
  input  logic                           IN_PB_RESET,
  input  logic                           start,
  input  logic [FRAME_BITS-1:0]          frame,
  output logic                           SRC_EN,
  output logic [FRAME_BITS+WORD_BITS-1:0] SRC_ADDR,
  input  logic [DATA_W-1:0]              SRC_DATA,
  output logic                           DST_EN,
  output logic                           DST_WE,
  output logic [15:0]                    DST_ADDR,
  output logic [DATA_W-1:0]              DST_DATA,
  output logic                           done
);

  logic                 readEn;
  logic [WORD_BITS-1:0] index;
  logic                 wrVld;
  logic [WORD_BITS-1:0] wrIndex;

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      readEn  <= 1'b0;
      index   <= '0;
      wrVld   <= 1'b0;
      wrIndex <= '0;
    end else begin
      // Write stage trails the read stage by exactly one cycle, matching
      // the source RAM's one-cycle read latency.
      wrVld   <= readEn;
      wrIndex <= index;
      if (start) begin
        readEn <= 1'b1;
        index  <= '0;
      end else if (readEn) begin
        index <= index + WORD_BITS'(1);
        if (index == {WORD_BITS{1'b1}}) begin
          readEn <= 1'b0;
        end
      end
    end
  end

  assign done     = readEn && (index == {WORD_BITS{1'b1}});
  assign SRC_EN   = readEn;
  assign SRC_ADDR = readEn ? {frame, index} : '0;
  assign DST_EN   = wrVld;
  assign DST_WE   = wrVld;
  assign DST_ADDR = wrVld ? 16'(wrIndex) : 16'h0000;
  // Gated so that reset forces the whole write port to zero at once.
  assign DST_DATA = wrVld ? SRC_DATA : '0;

endmodule

// File: rtl/frame_blit_scheduler.sv
// Arbitrates timer (copy+draw) and keyboard (frame select) IRQs over one copy path.
// Latency: GPU_DRAW 1027 cycles after the IDLE cycle that samples TICK_IRQ.
// No backpressure inside a copy; requests are only sampled in IDLE, tick first.
//
// Ports: CLK, IN_PB_RESET (async active-low); TICK_IRQ/IACK/IEND and
// SEL_IRQ/SEL_DATA/IACK/IEND interrupt handshakes; SRC_* source RAM read;
// DST_* VRAM write; GPU_READY/GPU_DRAW; CUR_FRAME and BUSY status.
// Optional macro FRAME_AUTO_ADVANCE_EN: step CUR_FRAME after each draw.
module frame_blit_scheduler
  import gfx_pkg::*;
#(
  parameter int         FRAME_BITS = FRAME_BITS_DEF,
  parameter int         WORD_BITS  = WORD_BITS_DEF,
  parameter int         DATA_W     = DATA_W_DEF,
  parameter logic [7:0] SEL_BASE   = SEL_BASE_DEF
) (
  input  logic                            CLK,
  input  logic                            IN_PB_RESET,
  input  logic                            TICK_IRQ,
  output logic                            TICK_IACK,
  output logic                            TICK_IEND,
  input  logic                            SEL_IRQ,
  input  logic [7:0]                      SEL_DATA,
  output logic                            SEL_IACK,
  output logic                            SEL_IEND,
  output logic                            SRC_EN,
  output logic [FRAME_BITS+WORD_BITS-1:0] SRC_ADDR,
  input  logic [DATA_W-1:0]               SRC_DATA,
  output logic                            DST_EN,
  output logic                            DST_WE,
  output logic [15:0]                     DST_ADDR,
  output logic [DATA_W-1:0]               DST_DATA,
  input  logic                            GPU_READY,
  output logic                            GPU_DRAW,
  output logic [FRAME_BITS-1:0]           CUR_FRAME
  ,
  output logic                            BUSY
);

  blitState_t            state;
  logic [FRAME_BITS-1:0] curFrame;
  logic [7:0]            selCode;
  logic                  startCopy;
  logic                  copyDone;

  // Launch the pipe from T_ACK so its first read lands in the first COPY cycle.
  assign startCopy = (state == T_ACK) && GPU_READY;

  // Strobes are registered: each is set on the edge that enters the state
  // in which it must be seen, and cleared by default on every other edge.
  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      state     <= IDLE;
      curFrame  <= '0;
      selCode   <= 8'h00;
      TICK_IACK <= 1'b0;
      TICK_IEND <= 1'b0;
      SEL_IACK  <= 1'b0;
      SEL_IEND  <= 1'b0;
      GPU_DRAW  <= 1'b0;
    end else begin
      TICK_IACK <= 1'b0;
      TICK_IEND <= 1'b0;
      SEL_IACK  <= 1'b0;
      SEL_IEND  <= 1'b0;
      GPU_DRAW  <= 1'b0;
      case (state)
        IDLE: begin
          if (TICK_IRQ) begin
            state     <= T_ACK;
            TICK_IACK <= 1'b1;
          end else if (SEL_IRQ) begin
            state    <= S_ACK;
            SEL_IACK <= 1'b1;
          end
        end
        T_ACK: begin
          if (GPU_READY) begin
            state <= COPY;
          end else begin
            state     <= SKIP;
            TICK_IEND <= 1'b1;
          end
        end
        COPY: begin
          if (copyDone) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state     <= DRAW;
          GPU_DRAW  <= 1'b1;
          TICK_IEND <= 1'b1;
        end
        DRAW: begin
          state <= IDLE;
`ifdef FRAME_AUTO_ADVANCE_EN
          curFrame <= curFrame + FRAME_BITS'(1);
`endif
        end
        SKIP: begin
          state <= IDLE;
        end
        S_ACK: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          // 8-bit wrap: codes below the base turn into large offsets.
          selCode  <= SEL_DATA - SEL_BASE;
          state    <= S_END;
          SEL_IEND <= 1'b1;
        end
        S_END: begin
          if (selValid(selCode, FRAME_BITS)) begin
            curFrame <= selCode[FRAME_BITS-1:0];
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  blit_pipe #(
    .FRAME_BITS(FRAME_BITS),
    .WORD_BITS (WORD_BITS),
    .DATA_W    (DATA_W)
  ) uPipe (
    .CLK        (CLK),
    .IN_PB_RESET(IN_PB_RESET),
    .start      (startCopy),
    .frame      (curFrame),
    .SRC_EN     (SRC_EN),
    .SRC_ADDR   (SRC_ADDR),
    .SRC_DATA   (SRC_DATA),
    .DST_EN     (DST_EN),
    .DST_WE     (DST_WE),
    .DST_ADDR   (DST_ADDR),
    .DST_DATA   (DST_DATA),
    .done       (copyDone)
  );

  assign CUR_FRAME = curFrame;
  assign BUSY      = (state != IDLE);

endmodule
